// File: rtl/input_debounce_irq_if.sv
// -----------------------------------------------------------------------------
// input_debounce_irq_if
//
// Purpose:
//   Bundles the signals between the input-conditioning stage and the CPU
//   side (raw pad levels, interrupt control, conditioned value and flags).
//
// Modports:
//   master : CPU/board side. Drives raw_in, irq_en, irq_ack (and edge_pol).
//            Receives port_out, flags, irq.
//   slave  : input_debounce_irq. Receives the inputs and drives the outputs.
//
// Signals:
//   raw_in   [WIDTH]  unsynchronized button/switch levels
//   irq_en   [WIDTH]  per-bit interrupt enable
//   irq_ack  [WIDTH]  per-bit flag clear (level, sampled every cycle)
//   edge_pol [WIDTH]  per-bit edge select, 0 = rising, 1 = falling
//                     (present only with INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN)
//   port_out [WIDTH]  debounced, registered input value
//   flags    [WIDTH]  pending edge flags, registered
//   irq               OR of flags
//
// Optional feature macro: INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
// -----------------------------------------------------------------------------
interface input_debounce_irq_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_ack;
`ifdef INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
  logic [WIDTH-1:0] edge_pol;
`endif
  logic [WIDTH-1:0] port_out;
  logic [WIDTH-1:0] flags;
  logic             irq;

`ifdef INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
  modport master (
    output raw_in, irq_en, irq_ack, edge_pol,
    input  port_out, flags, irq
  );

  modport slave (
    input  raw_in, irq_en, irq_ack, edge_pol,
    output port_out, flags, irq
  );
`else
  modport master (
    output raw_in, irq_en, irq_ack,
    input  port_out, flags, irq
  );

  modport slave (
    input  raw_in, irq_en, irq_ack,
    output port_out, flags, irq
  );
`endif

endinterface : input_debounce_irq_if

// File: rtl/input_debounce_irq.sv
// -----------------------------------------------------------------------------
// input_debounce_irq
//
// Purpose:
//   Conditions raw push-button / switch levels for the CPU input ports and
//   interrupt lines. Each bit runs through a 2-flop synchronizer and a
//   per-bit debounce counter; the accepted level is presented on port_out.
//   A qualifying edge of port_out latches a sticky pending flag (if enabled
//   for that bit) and irq stays high while any flag is pending.
//
// Parameters:
//   WIDTH      number of independent input bits
//   DEB_CYCLES consecutive cycles a synchronized level must hold (1..255)
//   CNT_W      debounce counter width, 2**CNT_W > DEB_CYCLES
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous reset, active low
//   bus    input_debounce_irq_if.slave
//            in : raw_in, irq_en, irq_ack (edge_pol with the macro)
//            out: port_out, flags, irq
//
// Optional feature macro: INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
//   Defined   : bus.edge_pol selects rising (0) or falling (1) edges per bit.
//   Undefined : only rising edges of port_out set flags.
//
// Latency: a stable raw level reaches port_out 2 + DEB_CYCLES rising edges
// after the first edge that samples it (2 synchronizer stages, then the
// counter has to observe DEB_CYCLES consecutive differing samples).
// -----------------------------------------------------------------------------
module input_debounce_irq #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input_debounce_irq_if.slave  bus
);

  // Elaboration-time guard on the parameter ranges.
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb_cycles
    $error("input_debounce_irq: DEB_CYCLES must be within 1..255");
  end
  if ((64'd1 << CNT_W) <= 64'(DEB_CYCLES)) begin : g_bad_cnt_w
    $error("input_debounce_irq: CNT_W too narrow for DEB_CYCLES");
  end

  // Terminal count: the sample that completes DEB_CYCLES consecutive
  // differing cycles is the one seen while the counter holds DEB_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_q,    sync1_d;
  logic [WIDTH-1:0] sync2_q,    sync2_d;
  logic [WIDTH-1:0] port_out_q, port_out_d;
  logic [WIDTH-1:0] flags_q,    flags_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-bit qualifying edge of port_out on this clock.
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] edge_hit;

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    sync1_d    = bus.raw_in;
    sync2_d    = sync1_q;
    port_out_d = port_out_q;

    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];

      if (sync2_q[i] == port_out_q[i]) begin
        // Back at (or still at) the accepted level: any partial excursion is
        // discarded, so a glitch must start over from zero.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Held long enough: accept the new level.
        port_out_d[i] = sync2_q[i];
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge qualification and pending flags
  // ---------------------------------------------------------------------------
  // A bit qualifies only on the clock where port_out actually updates.
  assign changed = port_out_d ^ port_out_q;

`ifdef INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
  // On an update the new value is 1 for a rise and 0 for a fall; XOR with
  // the polarity select turns a fall into a hit when edge_pol is 1.
  assign edge_hit = changed & (port_out_d ^ bus.edge_pol);
`else
  // Rising edges only.
  assign edge_hit = changed & port_out_d;
`endif

  always_comb begin
    // Ack clears first, then a new enabled edge sets: a set and an ack on
    // the same bit in the same cycle leaves the flag set. An edge seen while
    // the bit is disabled is dropped, and disabling never clears a flag.
    flags_d = (flags_q & ~bus.irq_ack) | (edge_hit & bus.irq_en);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      port_out_q <= '0;
      flags_q    <= '0;
      // NOTE: the counter array is reset like any other state: it is a bank
      // of flops, not a RAM, and a count surviving reset would shorten the
      // first debounce after release.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge; sync2 must see the old sync1, not the new one.
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      port_out_q <= port_out_d;
      flags_q    <= flags_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.port_out = port_out_q;
  assign bus.flags    = flags_q;
  // OR of registered flags: glitch-free and high in the same cycle as the
  // flag that causes it.
  assign bus.irq      = |flags_q;

endmodule : input_debounce_irq

// File: tb/tb_input_debounce_irq.sv
// -----------------------------------------------------------------------------
// tb_input_debounce_irq
//
// Directed stimulus for input_debounce_irq with default parameters
// (WIDTH=8, DEB_CYCLES=4). The stimulus process pushes the expected
// port_out / flags / irq for a given cycle number into a queue; a monitor
// samples the outputs on every falling clock edge and checks every entry
// due for that cycle.
// -----------------------------------------------------------------------------
module tb_input_debounce_irq;

  typedef struct {
    int          cyc;
    logic [7:0]  po;
    logic [7:0]  fl;
    logic        irq;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fails;
  exp_t sb [$];

  input_debounce_irq_if #(.WIDTH(8)) bus ();

  input_debounce_irq #(
    .WIDTH      (8),
    .DEB_CYCLES (4),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges so far; stimulus reads it 1 ns after an edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [7:0] po, input logic [7:0] fl,
                      input logic irq, input string name);
    exp_t e;
    e.cyc  = c;
    e.po   = po;
    e.fl   = fl;
    e.irq  = irq;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input exp_t e);
    n_checks++;
    if (e.cyc != cyc) begin
      n_fails++;
      $display("FAIL %s: due at cycle %0d, reached at cycle %0d", e.name, e.cyc, cyc);
    end else if (bus.port_out !== e.po || bus.flags !== e.fl || bus.irq !== e.irq) begin
      n_fails++;
      $display("FAIL %s @cyc %0d: got port_out=%h flags=%h irq=%b, expected port_out=%h flags=%h irq=%b",
               e.name, cyc, bus.port_out, bus.flags, bus.irq, e.po, e.fl, e.irq);
    end
  endtask

  // Monitor: pops every expectation due at (or overdue by) this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      check(sb.pop_front());
    end
  end

  initial begin
    int b;
    n_checks    = 0;
    n_fails     = 0;
    reset       = 1'b0;
    bus.raw_in  = 8'h00;
    bus.irq_en  = 8'h00;
    bus.irq_ack = 8'h00;
`ifdef INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
    bus.edge_pol = 8'h00;
`endif

    // --- Reset and steady input --------------------------------------------
    push(1, 8'h00, 8'h00, 1'b0, "reset_state");
    #12;
    reset = 1'b1;
    b = cyc;
    for (int i = 1; i <= 50; i++) push(b + i, 8'h00, 8'h00, 1'b0, "steady_idle");
    step(50);

    // --- Clean press on bit 2 ----------------------------------------------
    b = cyc;
    bus.irq_en = 8'h04;
    bus.raw_in = 8'h04;
    push(b + 5, 8'h00, 8'h00, 1'b0, "press_pre");
    push(b + 6, 8'h04, 8'h04, 1'b1, "press_edge");
    step(8);

    // --- 3-cycle glitch on bit 3 is rejected -------------------------------
    b = cyc;
    bus.irq_en = 8'h0C;
    bus.raw_in = 8'h0C;
    for (int i = 1; i <= 10; i++) push(b + i, 8'h04, 8'h04, 1'b1, "glitch3_reject");
    step(3);
    bus.raw_in = 8'h04;
    step(7);

    // --- 4-cycle pulse on bit 3 passes for exactly 4 cycles ----------------
    b = cyc;
    bus.raw_in = 8'h0C;
    push(b + 5, 8'h04, 8'h04, 1'b1, "pulse4_pre");
    for (int i = 6; i <= 9; i++) push(b + i, 8'h0C, 8'h0C, 1'b1, "pulse4_high");
    push(b + 10, 8'h04, 8'h0C, 1'b1, "pulse4_low");
    step(4);
    bus.raw_in = 8'h04;
    step(8);

    // --- Ack bit 3, release bit 2 (falling edge sets nothing) --------------
    b = cyc;
    bus.irq_ack = 8'h08;
    bus.raw_in  = 8'h00;
    push(b + 1, 8'h04, 8'h04, 1'b1, "ack_bit3");
    push(b + 5, 8'h04, 8'h04, 1'b1, "release2_pre");
    push(b + 6, 8'h00, 8'h04, 1'b1, "release2_no_flag");
    step(1);
    bus.irq_ack = 8'h00;
    step(7);

    // --- Ack and set collide on bit 2: set wins; ack alone then clears -----
    b = cyc;
    bus.raw_in = 8'h04;
    push(b + 5, 8'h00, 8'h04, 1'b1, "collision_pre");
    push(b + 6, 8'h04, 8'h04, 1'b1, "collision_set_wins");
    push(b + 7, 8'h04, 8'h00, 1'b0, "ack_alone_clears");
    step(5);
    bus.irq_ack = 8'h04;
    step(1);
    step(1);
    bus.irq_ack = 8'h00;
    step(2);

    // --- Disabled edge on bit 0 is lost ------------------------------------
    b = cyc;
    bus.irq_en = 8'h00;
    bus.raw_in = 8'h05;
    push(b + 5, 8'h04, 8'h00, 1'b0, "disabled_pre");
    push(b + 6, 8'h05, 8'h00, 1'b0, "disabled_edge");
    push(b + 9, 8'h05, 8'h00, 1'b0, "reenable_no_memory");
    push(b + 10, 8'h05, 8'h00, 1'b0, "reenable_no_memory");
    step(8);
    bus.irq_en = 8'h01;
    step(3);

    // --- Reset two cycles into the debounce of bit 1 -----------------------
    b = cyc;
    bus.raw_in = 8'h07;
    push(b + 3, 8'h05, 8'h00, 1'b0, "pre_reset");
    push(b + 4, 8'h00, 8'h00, 1'b0, "reset_async_clear");
    push(b + 5, 8'h00, 8'h00, 1'b0, "reset_held");
    push(b + 10, 8'h00, 8'h00, 1'b0, "post_reset_pre");
    push(b + 11, 8'h07, 8'h01, 1'b1, "post_reset_full_latency");
    step(4);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(7);

`ifdef INPUT_DEBOUNCE_IRQ_EDGE_SEL_EN
    // --- Falling-edge select on bit 0 --------------------------------------
    b = cyc;
    bus.edge_pol = 8'h01;
    bus.irq_ack  = 8'h01;
    bus.raw_in   = 8'h06;
    push(b + 1, 8'h07, 8'h00, 1'b0, "pol_ack");
    push(b + 6, 8'h06, 8'h01, 1'b1, "pol_fall_sets");
    push(b + 8, 8'h06, 8'h00, 1'b0, "pol_ack2");
    push(b + 13, 8'h07, 8'h00, 1'b0, "pol_rise_ignored");
    push(b + 19, 8'h07, 8'h00, 1'b0, "pol_fall_pre");
    push(b + 20, 8'h06, 8'h01, 1'b1, "pol_fall_edge");
    step(1);
    bus.irq_ack = 8'h00;
    step(6);
    bus.irq_ack = 8'h01;
    bus.raw_in  = 8'h07;
    step(1);
    bus.irq_ack = 8'h00;
    step(6);
    bus.raw_in = 8'h06;
    step(8);
`else
    // --- Falling edge on bit 0 sets nothing in the rising-only build -------
    b = cyc;
    bus.irq_ack = 8'h01;
    bus.raw_in  = 8'h06;
    push(b + 1, 8'h07, 8'h00, 1'b0, "fall_ack");
    push(b + 5, 8'h07, 8'h00, 1'b0, "fall_pre");
    push(b + 6, 8'h06, 8'h00, 1'b0, "fall_ignored");
    step(1);
    bus.irq_ack = 8'h00;
    step(7);
`endif

    // Every expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL queue_drained: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_input_debounce_irq
